// File: rtl/matrix_pkg.sv
// Shared types and constants for the RGB matrix scan-capture block.
package matrix_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 8;

    typedef logic [MATRIX_COLS-1:0] row_t;

    typedef struct packed {
        row_t r;
        row_t g;
        row_t b;
    } rgb_row_t;

    // One synchronized scan sample: the row select plus the raw column data.
    typedef struct packed {
        logic [2:0] sel;
        rgb_row_t   pix;
    } sample_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LATCH  = 2'd2
    } cap_state_t;

    // Column drive is active-low; the buffers store lit pixels as ones.
    function automatic rgb_row_t to_lit(input rgb_row_t raw);
        return ~raw;
    endfunction

endpackage

// File: rtl/scan_sync.sv
// Two-flop synchronizer for the asynchronous scan bus.
module scan_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking assignments so both stages sample before either updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/matrix_scan_capture.sv
// Captures a scanned 8x8 RGB matrix into a double-buffered frame store.
// Optional frame counter enabled by macro SCAN_CAPTURE_STATS_EN.
module matrix_scan_capture
    import matrix_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        CLK,
    input  logic        Clear_n,
    input  logic [7:0]  DATA_R,
    input  logic [7:0]  DATA_G,
    input  logic [7:0]  DATA_B,
    input  logic [2:0]  S,
    input  logic        COMM,
    input  logic [2:0]  rd_row,
    output logic [7:0]  rd_r,
    output logic [7:0]  rd_g,
    output logic [7:0]  rd_b,
    output logic        frame_done,
    output logic        scan_lost,
    output logic [15:0] frame_cnt
);

    localparam int SYNC_W = $bits(sample_t) + 1;
    localparam int SW     = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    logic [SYNC_W-1:0] sync_out;
    sample_t           sample;
    logic              comm_s;

    scan_sync #(.WIDTH(SYNC_W)) u_sync (
        .clk   (CLK),
        .rst_n (Clear_n),
        .d     ({S, DATA_R, DATA_G, DATA_B, COMM}),
        .q     (sync_out)
    );

    assign {sample, comm_s} = sync_out;

    cap_state_t        state_q,  state_d;
    logic [SW-1:0]     settle_q, settle_d;
    sample_t           prev_q;
    logic [TW-1:0]     tcnt_q,   tcnt_d;
    logic              scan_lost_q, scan_lost_d;
    logic [MATRIX_ROWS-1:0] seen_q, seen_d;
    rgb_row_t          work_q   [MATRIX_ROWS];
    rgb_row_t          work_d   [MATRIX_ROWS];
    rgb_row_t          shadow_q [MATRIX_ROWS];
    rgb_row_t          shadow_d [MATRIX_ROWS];
    rgb_row_t          rd_q,     rd_d;
    logic              frame_done_q, frame_done_d;

    logic     changed;
    logic     sel_changed;
    logic     lost_rise;
    rgb_row_t lit_pix;

    assign changed     = (sample != prev_q);
    assign sel_changed = (sample.sel != prev_q.sel);
    // prev_q held steady through SETTLE, so it is the value being latched.
    assign lit_pix     = to_lit(prev_q.pix);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE: begin
                settle_d = '0;
                if (comm_s && changed) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!comm_s) begin
                    state_d  = ST_IDLE;
                    settle_d = '0;
                end else if (changed) begin
                    settle_d = '0;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d  = ST_LATCH;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tcnt_d = tcnt_q;
        if (sel_changed)               tcnt_d = '0;
        else if (tcnt_q != TIMEOUT_MAX) tcnt_d = tcnt_q + 1'b1;
        scan_lost_d = (tcnt_d == TIMEOUT_MAX);
        lost_rise   = scan_lost_d && !scan_lost_q;
    end

    always_comb begin
        work_d       = work_q;
        shadow_d     = shadow_q;
        seen_d       = seen_q;
        frame_done_d = 1'b0;
        if (state_q == ST_LATCH) begin
            if (prev_q.sel == 3'd0 && seen_q == '1) begin
                shadow_d     = work_q;
                work_d       = '{default: '0};
                work_d[0]    = lit_pix;
                seen_d       = {{(MATRIX_ROWS-1){1'b0}}, 1'b1};
                frame_done_d = 1'b1;
            end else begin
                work_d[prev_q.sel] = rgb_row_t'(work_q[prev_q.sel] | lit_pix);
                seen_d[prev_q.sel] = 1'b1;
            end
        end
        // A stalled source invalidates the partial frame but not the last good one.
        if (lost_rise) begin
            work_d = '{default: '0};
            seen_d = '0;
        end
        rd_d = shadow_q[rd_row];
    end

    always_ff @(posedge CLK or negedge Clear_n) begin
        if (!Clear_n) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            prev_q       <= '0;
            tcnt_q       <= '0;
            scan_lost_q  <= 1'b0;
            seen_q       <= '0;
            // NOTE: the frame buffers are reset too, so readback after reset is defined as blank.
            work_q       <= '{default: '0};
            shadow_q     <= '{default: '0};
            rd_q         <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            prev_q       <= sample;
            tcnt_q       <= tcnt_d;
            scan_lost_q  <= scan_lost_d;
            seen_q       <= seen_d;
            work_q       <= work_d;
            shadow_q     <= shadow_d;
            rd_q         <= rd_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rd_r       = rd_q.r;
    assign rd_g       = rd_q.g;
    assign rd_b       = rd_q.b;
    assign frame_done = frame_done_q;
    assign scan_lost  = scan_lost_q;

`ifdef SCAN_CAPTURE_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_done_d) frame_cnt_d = frame_cnt_q + 16'd1;
    end

    always_ff @(posedge CLK or negedge Clear_n) begin
        if (!Clear_n) frame_cnt_q <= '0;
        else          frame_cnt_q <= frame_cnt_d;
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Self-checking bench for matrix_scan_capture against a row/frame-level model.
module tb_matrix_scan_capture;

    logic        CLK = 1'b0;
    logic        Clear_n;
    logic [7:0]  DATA_R, DATA_G, DATA_B;
    logic [2:0]  S;
    logic        COMM;
    logic [2:0]  rd_row;
    logic [7:0]  rd_r, rd_g, rd_b;
    logic        frame_done;
    logic        scan_lost;
    logic [15:0] frame_cnt;

    matrix_scan_capture #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)) dut (
        .CLK        (CLK),
        .Clear_n    (Clear_n),
        .DATA_R     (DATA_R),
        .DATA_G     (DATA_G),
        .DATA_B     (DATA_B),
        .S          (S),
        .COMM       (COMM),
        .rd_row     (rd_row),
        .rd_r       (rd_r),
        .rd_g       (rd_g),
        .rd_b       (rd_b),
        .frame_done (frame_done),
        .scan_lost  (scan_lost),
        .frame_cnt  (frame_cnt)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;
    int fd_seen     = 0;

    always @(posedge CLK) if (frame_done === 1'b1) fd_seen <= fd_seen + 1;

    // Model: pixel rows as {r,g,b} lit bits, plus which rows the frame has seen.
    logic [23:0] m_work   [8];
    logic [23:0] m_shadow [8];
    logic [7:0]  m_seen;
    int          m_frames;
    logic [26:0] m_last;

    logic [23:0] cap_pre, cap_post;
    bit          cap_hit, cap_armed;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_work[i]   = '0;
            m_shadow[i] = '0;
        end
        m_seen = '0;
        m_last = '0;
    endtask

    task automatic model_latch(input int s, input logic [23:0] lit);
        if (s == 0 && m_seen == 8'hFF) begin
            for (int i = 0; i < 8; i++) begin
                m_shadow[i] = m_work[i];
                m_work[i]   = '0;
            end
            m_work[0] = lit;
            m_seen    = 8'h01;
            m_frames++;
        end else begin
            m_work[s]  = m_work[s] | lit;
            m_seen[s]  = 1'b1;
        end
    endtask

    // Holds one scan value for `hold` cycles. Holds of 12+ cycles settle; holds of 3 or fewer never do.
    task automatic drive(input int s, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b, input int hold, input bit comm);
        logic [26:0] val;
        S = 3'(s); DATA_R = r; DATA_G = g; DATA_B = b; COMM = comm;
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            if (cap_armed) begin
                cap_post  = {rd_r, rd_g, rd_b};
                cap_armed = 1'b0;
            end
            if (frame_done === 1'b1) begin
                cap_pre   = {rd_r, rd_g, rd_b};
                cap_armed = 1'b1;
                cap_hit   = 1'b1;
            end
        end
        val = {3'(s), r, g, b};
        if (hold >= 12 && comm && val != m_last) model_latch(s, ~{r, g, b});
        m_last = val;
    endtask

    function automatic logic [7:0] rnd();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic check_readback(input string tag);
        for (int k = 0; k < 8; k++) begin
            rd_row = 3'(k);
            @(posedge CLK); #1;
            check($sformatf("%s_r%0d_r", tag, k), {24'd0, rd_r}, {24'd0, m_shadow[k][23:16]});
            check($sformatf("%s_r%0d_g", tag, k), {24'd0, rd_g}, {24'd0, m_shadow[k][15:8]});
            check($sformatf("%s_r%0d_b", tag, k), {24'd0, rd_b}, {24'd0, m_shadow[k][7:0]});
        end
    endtask

    task automatic random_rows(input int first, input int last);
        for (int k = first; k <= last; k++) drive(k, rnd(), rnd(), rnd(), 20, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] old_row3;
        logic [7:0]  d2;
        m_frames = 0;
        cap_hit = 0; cap_armed = 0; cap_pre = '0; cap_post = '0;
        model_reset();
        Clear_n = 1'b0;
        DATA_R = '0; DATA_G = '0; DATA_B = '0; S = '0; COMM = 1'b0; rd_row = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_rd_b", {24'd0, rd_b}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        check("reset_scan_lost", {31'd0, scan_lost}, 32'd0);
        check("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        Clear_n = 1'b1;

        // Single-colour scan: blue diagonal.
        for (int k = 0; k < 8; k++) drive(k, 8'hFF, 8'hFF, ~(8'h80 >> k), 20, 1'b1);
        drive(0, 8'hFF, 8'hFF, 8'h7F, 20, 1'b1);
        check("single_frames", fd_seen, m_frames);
        check("single_frames_one", fd_seen, 1);
        for (int k = 0; k < 8; k++) begin
            rd_row = 3'(k);
            @(posedge CLK); #1;
            check($sformatf("single_r%0d_b", k), {24'd0, rd_b}, {24'd0, 8'h80 >> k});
            check($sformatf("single_r%0d_rg", k), {16'd0, rd_r, rd_g}, 32'd0);
        end

        // Colour merge on row 3, with a same-cycle copy/read on row 3.
        drive(3, 8'hFF, 8'hFE, 8'hFF, 20, 1'b1);
        random_rows(1, 2);
        random_rows(4, 6);
        drive(3, 8'h7F, 8'hFF, 8'hFF, 20, 1'b1);
        random_rows(7, 7);
        rd_row   = 3'd3;
        old_row3 = m_shadow[3];
        cap_hit  = 1'b0;
        drive(0, rnd(), rnd(), rnd(), 20, 1'b1);
        check("merge_frames", fd_seen, m_frames);
        check("copy_seen", {31'd0, cap_hit}, 32'd1);
        check("copy_pre_old", {8'd0, cap_pre}, {8'd0, old_row3});
        check("copy_post_new", {8'd0, cap_post}, {8'd0, m_shadow[3]});
        @(posedge CLK); #1;
        check("merge_r3_r", {24'd0, rd_r}, 32'h80);
        check("merge_r3_g", {24'd0, rd_g}, 32'h01);
        check("merge_r3_b", {24'd0, rd_b}, 32'h00);
        check_readback("merge");

        // Glitch on S inside a row-2 hold: row 5 must not count as seen.
        d2 = rnd();
        random_rows(1, 1);
        drive(2, d2, d2, d2, 14, 1'b1);
        drive(5, d2, d2, d2, 2, 1'b1);
        drive(2, d2, d2, d2, 20, 1'b1);
        random_rows(3, 4);
        random_rows(6, 7);
        drive(0, rnd(), rnd(), rnd(), 20, 1'b1);
        check("glitch_no_frame", fd_seen, m_frames);
        random_rows(5, 5);
        drive(0, rnd(), rnd(), rnd(), 20, 1'b1);
        check("glitch_frames", fd_seen, m_frames);
        check_readback("glitch");

        // Incomplete frame: row 7 only shown while COMM=0.
        random_rows(1, 6);
        drive(7, rnd(), rnd(), rnd(), 20, 1'b0);
        drive(0, rnd(), rnd(), rnd(), 20, 1'b1);
        check("incomplete_no_frame", fd_seen, m_frames);
        check_readback("incomplete");
        random_rows(7, 7);
        drive(0, rnd(), rnd(), rnd(), 20, 1'b1);
        check("incomplete_then_frame", fd_seen, m_frames);

        // Stall: S frozen on row 1.
        drive(1, rnd(), rnd(), rnd(), 90, 1'b1);
        check("stall_not_yet", {31'd0, scan_lost}, 32'd0);
        repeat (20) @(posedge CLK);
        #1;
        check("stall_lost", {31'd0, scan_lost}, 32'd1);
        m_work = '{default: '0};
        m_seen = '0;
        drive(2, rnd(), rnd(), rnd(), 20, 1'b1);
        check("stall_recovered", {31'd0, scan_lost}, 32'd0);
        check_readback("stall_shadow");
        random_rows(3, 7);
        drive(0, rnd(), rnd(), rnd(), 20, 1'b1);
        check("stall_no_frame", fd_seen, m_frames);
        random_rows(1, 1);
        drive(0, rnd(), rnd(), rnd(), 20, 1'b1);
        check("stall_frames", fd_seen, m_frames);
        check_readback("post_stall");

        // Reset mid-frame, then three full frames.
        random_rows(1, 3);
        rd_row = 3'd0;
        #3;
        Clear_n = 1'b0;
        #1;
        check("midrst_rd_r", {24'd0, rd_r}, 32'd0);
        check("midrst_rd_g", {24'd0, rd_g}, 32'd0);
        check("midrst_rd_b", {24'd0, rd_b}, 32'd0);
        check("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        check("midrst_scan_lost", {31'd0, scan_lost}, 32'd0);
        check("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        DATA_R = '0; DATA_G = '0; DATA_B = '0; S = '0; COMM = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        Clear_n = 1'b1;
        check_readback("after_rst");
        check("after_rst_frames", fd_seen, m_frames);
        for (int f = 0; f < 3; f++) random_rows(0, 7);
        drive(0, rnd(), rnd(), rnd(), 20, 1'b1);
        check("final_frames", fd_seen, m_frames);
`ifdef SCAN_CAPTURE_STATS_EN
        check("final_frame_cnt", {16'd0, frame_cnt}, 32'd3);
`else
        check("final_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
        check_readback("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
